valid_stream_checker: RTL and testbench
=======================================

Name: valid_stream_checker

Overview:
- Receiving end of the clk/valid handshake that benches drive into a DUT.
- Consumes the DUT's out_valid/out_data stream and checks every accepted beat against an expected incrementing pattern.
- Counts beats and mismatches, and runs an idle watchdog.
- Raises done/pass so the bench ends on an observed result, not on a fixed process time.

Parameters:
- DATA_W, 16: width of checked data.
- EXP_BEATS, 100: beats expected per run; must be >= 1.
- SEED, 0: expected value of the first beat.
- STEP, 1: increment between consecutive expected values, modulo 2^DATA_W.
- TIMEOUT_CYC, 200: maximum consecutive cycles without a beat while armed; must be >= 1.
- CNT_W, 16: width of the beat and error counters; must satisfy 2^CNT_W > EXP_BEATS.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle pulse that arms a run; ignored unless in IDLE, DONE or TOUT.
- in_valid, input, 1: beat present (DUT out_valid).
- in_data, input, DATA_W: beat payload (DUT out_data).
- in_ready, output, 1: checker accepts a beat this cycle.
- beat_cnt, output, CNT_W: beats accepted in the current run.
- err_cnt, output, CNT_W: mismatching beats in the current run.
- first_err_idx, output, CNT_W: beat index (0-based) of the first mismatch.
- first_err_data, output, DATA_W: received data at the first mismatch.
- done, output, 1: run ended with EXP_BEATS beats; level.
- pass, output, 1: done and err_cnt == 0; level.
- timeout, output, 1: watchdog fired; level.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; expected-value register = SEED; watchdog = 0.
- FSM states: IDLE, RUN, DONE, TOUT.
- IDLE: in_ready=0. On start: clear beat_cnt, err_cnt, first_err_*, done, pass, timeout; load expected=SEED; clear watchdog; go to RUN on the next edge.
- RUN: in_ready=1 combinationally from state only; it never depends on in_valid.
- Accept rule: a beat is accepted when in_valid && in_ready at a rising edge. in_valid is sampled only in RUN; beats outside RUN are dropped and not counted.
- On an accepted beat:
  - beat_cnt += 1; expected += STEP with wrap-around mod 2^DATA_W.
  - If in_data != expected: err_cnt += 1 (saturating at all-ones). If this is the first error, latch first_err_idx = beat_cnt (pre-increment value) and first_err_data = in_data.
  - Watchdog clears to 0.
- In RUN with no accepted beat: watchdog += 1. When it reaches TIMEOUT_CYC, go to TOUT and set timeout=1 on that edge.
- Completion: when the accepted beat makes beat_cnt == EXP_BEATS, go to DONE on the same edge. done=1; pass=1 iff no error was recorded, including an error on the final beat itself.
- Latency: counters and flags update on the edge that accepts the beat, so they are visible the next cycle. done/pass/timeout assert one edge after the triggering condition.
- Simultaneous events: a beat accepted in the cycle the watchdog would reach TIMEOUT_CYC wins. Watchdog clears, no timeout.
- DONE and TOUT: in_ready=0; all status held until start or rst. start re-arms exactly as from IDLE.
- start while in RUN: ignored; the run continues.
- Reset mid-run: all state and outputs return to reset values immediately and asynchronously. No partial results are kept.
- Arithmetic: comparison is a full DATA_W equality; expected uses an unsigned wrapping add; counters are unsigned.

Test Plan:
- Clean run: DATA_W=16, SEED=0, STEP=1, EXP_BEATS=100. Start, then in_valid=1 for 100 cycles with data 0..99 -> done=1, pass=1, beat_cnt=100, err_cnt=0, timeout=0.
- Gapped stream: same data, in_valid toggling 1/0 every cycle -> done after 199 cycles of RUN, beat_cnt=100, pass=1, no timeout (each gap is 1 cycle, well under 200).
- Corruption: beat 37 sent as 0xBEEF, beat 80 as 0 -> err_cnt=2, first_err_idx=37, first_err_data=0xBEEF, done=1, pass=0.
- Watchdog: TIMEOUT_CYC=10. Send 5 good beats, then hold in_valid=0 -> timeout=1 exactly 10 cycles after the last beat; beat_cnt=5; done=0; in_ready=0.
- Wrap: SEED=0xFFFE, STEP=1, EXP_BEATS=4, data 0xFFFE, 0xFFFF, 0x0000, 0x0001 -> pass=1.
- Reset mid-run: assert rst after beat 50 -> all outputs 0 the same cycle. A new start plus a clean 100-beat run -> pass=1, beat_cnt=100.

Source files
------------

// File: rtl/valid_stream_checker_if.sv
// Purpose: valid/ready beat channel between a stream producer and valid_stream_checker.
// Latency: none, wires only.
// Backpressure: the slave drives in_ready; a beat moves when in_valid && in_ready at a rising edge.
interface valid_stream_checker_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  // Producer side: presents beats, observes ready.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  // Consumer side: samples beats, drives ready.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/valid_stream_checker.sv
// Purpose: checks an accepted beat stream against SEED + k*STEP, counts beats/errors, runs an idle watchdog.
// Latency: counters and flags update on the accepting edge; done/pass/timeout visible one edge after the cause.
// Backpressure: in_ready is high only in RUN, decoded from state alone; beats outside RUN are dropped.
module valid_stream_checker #(
  parameter int          DATA_W      = 16,
  parameter int          EXP_BEATS   = 100,
  parameter int unsigned SEED        = 0,
  parameter int unsigned STEP        = 1,
  parameter int          TIMEOUT_CYC = 200,
  parameter int          CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  valid_stream_checker_if.slave stream,
  output logic [CNT_W-1:0]     beat_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     first_err_idx,
  output logic [DATA_W-1:0]    first_err_data,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout
);

  // Watchdog must be able to hold the value TIMEOUT_CYC itself.
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [DATA_W-1:0] SEED_V    = DATA_W'(SEED);
  localparam logic [DATA_W-1:0] STEP_V    = DATA_W'(STEP);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(EXP_BEATS - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    TOUT = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] exp_q;
  logic [WD_W-1:0]   wd_q;

  logic in_run;
  logic arm;
  logic beat_acc;
  logic mismatch;
  logic last_beat;
  logic wd_fire;
  logic no_err_yet;

  // Ready comes from state only so the producer never sees a combinational loop.
  assign in_run          = (state_q == RUN);
  assign stream.in_ready = in_run;

  // Control decode shared by the FSM and the datapath.
  always_comb begin
    arm        = 1'b0;
    beat_acc   = 1'b0;
    mismatch   = 1'b0;
    last_beat  = 1'b0;
    wd_fire    = 1'b0;
    no_err_yet = (err_cnt == '0);
    // start re-arms from any resting state; a pulse during RUN is ignored.
    arm        = start && !in_run;
    beat_acc   = in_run && stream.in_valid;
    mismatch   = beat_acc && (stream.in_data != exp_q);
    last_beat  = beat_acc && (beat_cnt == LAST_IDX);
    // An accepted beat beats the watchdog in the same cycle.
    wd_fire    = in_run && !beat_acc && (wd_q == WD_LAST);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: completion takes priority over the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, TOUT: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_beat) begin
          state_d = DONE;
        end else if (wd_fire) begin
          state_d = TOUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: expected value, watchdog, counters, first-error capture and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q          <= SEED_V;
      wd_q           <= '0;
      beat_cnt       <= '0;
      err_cnt        <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
    end else if (arm) begin
      exp_q          <= SEED_V;
      wd_q           <= '0;
      beat_cnt       <= '0;
      err_cnt        <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
    end else if (beat_acc) begin
      beat_cnt <= beat_cnt + 1'b1;
      exp_q    <= exp_q + STEP_V;
      wd_q     <= '0;
      if (mismatch) begin
        if (err_cnt != CNT_MAX) begin
          err_cnt <= err_cnt + 1'b1;
        end
        // Saturation keeps err_cnt nonzero, so zero reliably means "no error captured yet".
        if (no_err_yet) begin
          first_err_idx  <= beat_cnt;
          first_err_data <= stream.in_data;
        end
      end
      if (last_beat) begin
        done <= 1'b1;
        pass <= no_err_yet && !mismatch;
      end
    end else if (in_run) begin
      wd_q <= wd_q + 1'b1;
      if (wd_fire) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_valid_stream_checker.sv
// Purpose: directed bench for valid_stream_checker with a queue scoreboard fed by stimulus and drained by monitors.
// Latency: results are compared when done or timeout rises on a DUT.
// Backpressure: stimulus only presents beats while the DUT is expected to be in RUN.
module tb_valid_stream_checker;

  typedef struct {
    logic        done;
    logic        pass;
    logic        tout;
    logic [15:0] beats;
    logic [15:0] errs;
    logic [15:0] fidx;
    logic [15:0] fdata;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   start_edge = 0;
  int   last_edge = 0;
  int   evt_edge_a = 0;
  bit   prev_a = 1'b0;
  bit   prev_b = 1'b0;
  res_t qa[$];
  res_t qb[$];

  logic [15:0] beat_a, err_a, fidx_a, fdata_a;
  logic        done_a, pass_a, tout_a;
  logic [15:0] beat_b, err_b, fidx_b, fdata_b;
  logic        done_b, pass_b, tout_b;

  valid_stream_checker_if #(.DATA_W(16)) a_if ();
  valid_stream_checker_if #(.DATA_W(16)) b_if ();

  valid_stream_checker #(
    .DATA_W(16), .EXP_BEATS(100), .SEED(0), .STEP(1), .TIMEOUT_CYC(10), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stream(a_if.slave),
    .beat_cnt(beat_a), .err_cnt(err_a), .first_err_idx(fidx_a), .first_err_data(fdata_a),
    .done(done_a), .pass(pass_a), .timeout(tout_a)
  );

  valid_stream_checker #(
    .DATA_W(16), .EXP_BEATS(4), .SEED(16'hFFFE), .STEP(1), .TIMEOUT_CYC(200), .CNT_W(16)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stream(b_if.slave),
    .beat_cnt(beat_b), .err_cnt(err_b), .first_err_idx(fidx_b), .first_err_data(fdata_b),
    .done(done_b), .pass(pass_b), .timeout(tout_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cmp_res(input string tag, input res_t e, input res_t a);
    chk({tag, "_done"},  32'(a.done),  32'(e.done));
    chk({tag, "_pass"},  32'(a.pass),  32'(e.pass));
    chk({tag, "_tout"},  32'(a.tout),  32'(e.tout));
    chk({tag, "_beats"}, 32'(a.beats), 32'(e.beats));
    chk({tag, "_errs"},  32'(a.errs),  32'(e.errs));
    chk({tag, "_fidx"},  32'(a.fidx),  32'(e.fidx));
    chk({tag, "_fdata"}, 32'(a.fdata), 32'(e.fdata));
  endtask

  function automatic res_t mk(input logic d, input logic p, input logic t, input logic [15:0] b,
                              input logic [15:0] e, input logic [15:0] fi, input logic [15:0] fd);
    res_t r;
    r.done = d; r.pass = p; r.tout = t; r.beats = b; r.errs = e; r.fidx = fi; r.fdata = fd;
    return r;
  endfunction

  // Monitor A: pops one expected result whenever a run ends (done or timeout rises).
  always @(negedge clk) begin
    res_t act;
    res_t e;
    if (!rst && (done_a || tout_a) && !prev_a) begin
      evt_edge_a = cyc;
      act = mk(done_a, pass_a, tout_a, beat_a, err_a, fidx_a, fdata_a);
      if (qa.size() == 0) begin
        chk("a_unexpected_end", 32'(qa.size()), 32'd1);
      end else begin
        e = qa.pop_front();
        cmp_res("a", e, act);
      end
    end
    prev_a = done_a || tout_a;
  end

  // Monitor B: same scheme for the wrap instance.
  always @(negedge clk) begin
    res_t act;
    res_t e;
    if (!rst && (done_b || tout_b) && !prev_b) begin
      act = mk(done_b, pass_b, tout_b, beat_b, err_b, fidx_b, fdata_b);
      if (qb.size() == 0) begin
        chk("b_unexpected_end", 32'(qb.size()), 32'd1);
      end else begin
        e = qb.pop_front();
        cmp_res("b", e, act);
      end
    end
    prev_b = done_b || tout_b;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit b, input logic v, input logic [15:0] d, input logic s);
    if (b) begin
      b_if.in_valid = v; b_if.in_data = d; start_b = s;
    end else begin
      a_if.in_valid = v; a_if.in_data = d; start_a = s;
    end
  endtask

  // Start a run, then send n beats of seed+i with gap idle cycles between them.
  task automatic send(input bit b, input int n, input int gap, input int bad0, input logic [15:0] val0,
                      input int bad1, input logic [15:0] val1, input logic [15:0] seed, input int start_at);
    logic [15:0] d;
    drive(b, 1'b0, 16'h0, 1'b1);
    step();
    start_edge = cyc;
    for (int i = 0; i < n; i++) begin
      d = seed + 16'(i);
      if (i == bad0) d = val0;
      if (i == bad1) d = val1;
      drive(b, 1'b1, d, (i == start_at));
      step();
      last_edge = cyc;
      drive(b, 1'b0, 16'h0, 1'b0);
      if (i < n - 1) repeat (gap) step();
    end
  endtask

  // Bounded wait for the monitor to drain the expected-result queue.
  task automatic wait_q(input bit b, input string name);
    for (int k = 0; k < 400; k++) begin
      if ((b ? qb.size() : qa.size()) == 0) break;
      step();
    end
    chk(name, 32'(b ? qb.size() : qa.size()), 32'd0);
    if (b) qb.delete(); else qa.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    a_if.in_valid = 1'b0; a_if.in_data = '0;
    b_if.in_valid = 1'b0; b_if.in_data = '0;
    repeat (3) step();
    chk("rst_beat_a", 32'(beat_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_tout_a", 32'(tout_a), 32'd0);
    chk("rst_ready_a", 32'(a_if.in_ready), 32'd0);
    chk("rst_ready_b", 32'(b_if.in_ready), 32'd0);
    rst = 1'b0;
    step();

    // Beats offered while IDLE are not counted.
    drive(1'b0, 1'b1, 16'h0, 1'b0);
    repeat (3) step();
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    chk("idle_drop_beat_a", 32'(beat_a), 32'd0);

    // Clean run, with a stray start pulse mid-run that must be ignored.
    qa.push_back(mk(1, 1, 0, 100, 0, 0, 0));
    send(1'b0, 100, 0, -1, 0, -1, 0, 16'h0, 50);
    wait_q(1'b0, "clean_result");
    chk("clean_run_edges", 32'(evt_edge_a - start_edge), 32'd100);
    chk("clean_ready_after_done", 32'(a_if.in_ready), 32'd0);

    // Gapped stream: one idle cycle between beats.
    qa.push_back(mk(1, 1, 0, 100, 0, 0, 0));
    send(1'b0, 100, 1, -1, 0, -1, 0, 16'h0, -1);
    wait_q(1'b0, "gapped_result");
    chk("gapped_run_edges", 32'(evt_edge_a - start_edge), 32'd199);

    // Corruption at beats 37 and 80.
    qa.push_back(mk(1, 0, 0, 100, 2, 37, 16'hBEEF));
    send(1'b0, 100, 0, 37, 16'hBEEF, 80, 16'h0000, 16'h0, -1);
    wait_q(1'b0, "corrupt_result");

    // Watchdog: five good beats then silence.
    qa.push_back(mk(0, 0, 1, 5, 0, 0, 0));
    send(1'b0, 5, 0, -1, 0, -1, 0, 16'h0, -1);
    wait_q(1'b0, "wd_result");
    chk("wd_fire_delay", 32'(evt_edge_a - last_edge), 32'd10);
    chk("wd_ready_after_tout", 32'(a_if.in_ready), 32'd0);

    // A beat landing on the cycle the watchdog would expire wins (gaps of 9 with limit 10).
    qa.push_back(mk(0, 0, 1, 3, 0, 0, 0));
    send(1'b0, 3, 9, -1, 0, -1, 0, 16'h0, -1);
    wait_q(1'b0, "wd_edge_result");
    chk("wd_edge_fire_delay", 32'(evt_edge_a - last_edge), 32'd10);

    // Reset mid-run after beat 50: outputs clear within the same cycle.
    send(1'b0, 51, 0, -1, 0, -1, 0, 16'h0, -1);
    chk("pre_rst_beat", 32'(beat_a), 32'd51);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_beat", 32'(beat_a), 32'd0);
    chk("midrst_err", 32'(err_a), 32'd0);
    chk("midrst_ready", 32'(a_if.in_ready), 32'd0);
    chk("midrst_flags", 32'({done_a, pass_a, tout_a}), 32'd0);
    step();
    rst = 1'b0;
    step();
    qa.push_back(mk(1, 1, 0, 100, 0, 0, 0));
    send(1'b0, 100, 0, -1, 0, -1, 0, 16'h0, -1);
    wait_q(1'b0, "post_rst_result");

    // Wrap-around expected sequence on instance B.
    qb.push_back(mk(1, 1, 0, 4, 0, 0, 0));
    send(1'b1, 4, 0, -1, 0, -1, 0, 16'hFFFE, -1);
    wait_q(1'b1, "wrap_result");

    // Error on the final beat must still clear pass.
    qb.push_back(mk(1, 0, 0, 4, 1, 3, 16'h0005));
    send(1'b1, 4, 0, 3, 16'h0005, -1, 0, 16'hFFFE, -1);
    wait_q(1'b1, "last_beat_err_result");

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
